// File: rtl/muldiv_issue_queue_if.sv
// Signal bundle between dispatch, the result buses, the mul/div execution lanes
// and the mul/div issue queue; the queue takes the slave side.
interface muldiv_issue_queue_if #(
  parameter int DEPTH   = 8,
  parameter int ALLOC_W = 3,
  parameter int CDB_W   = 3,
  parameter int NUM_MUL = 1,
  parameter int NUM_DIV = 1,
  parameter int ROB_W   = 5,
  parameter int XLEN    = 32
);
  logic                       flush;
  logic                       stall;
  logic [ROB_W-1:0]           rob_head;

  logic [ALLOC_W-1:0]         alloc_valid;
  logic [ALLOC_W*2-1:0]       alloc_op;
  logic [ALLOC_W*ROB_W-1:0]   alloc_rob;
  logic [ALLOC_W-1:0]         alloc_src1_rdy;
  logic [ALLOC_W-1:0]         alloc_src2_rdy;
  logic [ALLOC_W*ROB_W-1:0]   alloc_src1_tag;
  logic [ALLOC_W*ROB_W-1:0]   alloc_src2_tag;
  logic [ALLOC_W*XLEN-1:0]    alloc_src1_val;
  logic [ALLOC_W*XLEN-1:0]    alloc_src2_val;
  logic                       alloc_ready;

  logic [CDB_W-1:0]           cdb_valid;
  logic [CDB_W*ROB_W-1:0]     cdb_tag;
  logic [CDB_W*XLEN-1:0]      cdb_data;

  logic [NUM_MUL-1:0]         mul_issue_valid;
  logic [NUM_MUL*2-1:0]       mul_issue_op;
  logic [NUM_MUL*ROB_W-1:0]   mul_issue_rob;
  logic [NUM_MUL*XLEN-1:0]    mul_issue_a;
  logic [NUM_MUL*XLEN-1:0]    mul_issue_b;

  logic [NUM_DIV-1:0]         div_ready;
  logic [NUM_DIV-1:0]         div_issue_valid;
  logic [NUM_DIV*2-1:0]       div_issue_op;
  logic [NUM_DIV*ROB_W-1:0]   div_issue_rob;
  logic [NUM_DIV*XLEN-1:0]    div_issue_a;
  logic [NUM_DIV*XLEN-1:0]    div_issue_b;

  logic [$clog2(DEPTH+1)-1:0] occupancy;

  modport master (
    output flush, stall, rob_head,
    output alloc_valid, alloc_op, alloc_rob, alloc_src1_rdy, alloc_src2_rdy,
    output alloc_src1_tag, alloc_src2_tag, alloc_src1_val, alloc_src2_val,
    input  alloc_ready,
    output cdb_valid, cdb_tag, cdb_data,
    input  mul_issue_valid, mul_issue_op, mul_issue_rob, mul_issue_a, mul_issue_b,
    output div_ready,
    input  div_issue_valid, div_issue_op, div_issue_rob, div_issue_a, div_issue_b,
    input  occupancy
  );

  modport slave (
    input  flush, stall, rob_head,
    input  alloc_valid, alloc_op, alloc_rob, alloc_src1_rdy, alloc_src2_rdy,
    input  alloc_src1_tag, alloc_src2_tag, alloc_src1_val, alloc_src2_val,
    output alloc_ready,
    input  cdb_valid, cdb_tag, cdb_data,
    output mul_issue_valid, mul_issue_op, mul_issue_rob, mul_issue_a, mul_issue_b,
    input  div_ready,
    output div_issue_valid, div_issue_op, div_issue_rob, div_issue_a, div_issue_b,
    output occupancy
  );
endinterface

// File: rtl/muldiv_issue_queue.sv
// Mul/div reservation queue: multi-port allocate, CDB operand capture, and
// oldest-first issue (ROB-head relative age) to multiplier and divider lanes.
module muldiv_issue_queue #(
  parameter int DEPTH   = 8,
  parameter int ALLOC_W = 3,
  parameter int CDB_W   = 3,
  parameter int NUM_MUL = 1,
  parameter int NUM_DIV = 1,
  parameter int ROB_W   = 5,
  parameter int XLEN    = 32
) (
  input  logic                clk,
  input  logic                rst,
  muldiv_issue_queue_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [ROB_W-1:0] rob;
    logic             rdy1;
    logic             rdy2;
    logic [ROB_W-1:0] tag1;
    logic [ROB_W-1:0] tag2;
    logic [XLEN-1:0]  val1;
    logic [XLEN-1:0]  val2;
  } entry_t;

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] data;
  } wake_t;

  // Lowest-numbered matching bus wins when several broadcast the same tag.
  function automatic wake_t cdb_match(input logic [ROB_W-1:0] tag);
    wake_t w;
    w = '0;
    for (int k = 0; k < CDB_W; k++) begin
      if (!w.hit && bus.cdb_valid[k] && (bus.cdb_tag[k*ROB_W +: ROB_W] == tag)) begin
        w.hit  = 1'b1;
        w.data = bus.cdb_data[k*XLEN +: XLEN];
      end
    end
    return w;
  endfunction

  function automatic logic is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Queue state
  logic [DEPTH-1:0] valid;
  entry_t           ent [DEPTH];
  logic [OCC_W-1:0] occ_q;

  // Issue registers, already in the flat lane layout of the outputs
  logic [NUM_MUL-1:0]       mul_v_q;
  logic [NUM_MUL*2-1:0]     mul_op_q;
  logic [NUM_MUL*ROB_W-1:0] mul_rob_q;
  logic [NUM_MUL*XLEN-1:0]  mul_a_q;
  logic [NUM_MUL*XLEN-1:0]  mul_b_q;
  logic [NUM_DIV-1:0]       div_v_q;
  logic [NUM_DIV*2-1:0]     div_op_q;
  logic [NUM_DIV*ROB_W-1:0] div_rob_q;
  logic [NUM_DIV*XLEN-1:0]  div_a_q;
  logic [NUM_DIV*XLEN-1:0]  div_b_q;

  // Combinational results
  entry_t           alloc_ent  [ALLOC_W];
  logic             alloc_hit  [ALLOC_W];
  logic [IDX_W-1:0] alloc_slot [ALLOC_W];
  logic             alloc_ready_c;
  wake_t            ent_w1 [DEPTH];
  wake_t            ent_w2 [DEPTH];
  logic             mul_sel_vld [NUM_MUL];
  logic [IDX_W-1:0] mul_sel_idx [NUM_MUL];
  logic             div_sel_vld [NUM_DIV];
  logic [IDX_W-1:0] div_sel_idx [NUM_DIV];
  logic [DEPTH-1:0] issue_mask;
  logic [OCC_W-1:0] n_alloc;
  logic [OCC_W-1:0] n_issue;

  // Incoming ops, with same-cycle CDB bypass folded in for not-ready sources.
  always_comb begin
    for (int p = 0; p < ALLOC_W; p++) begin
      wake_t w1;
      wake_t w2;
      w1 = cdb_match(bus.alloc_src1_tag[p*ROB_W +: ROB_W]);
      w2 = cdb_match(bus.alloc_src2_tag[p*ROB_W +: ROB_W]);
      alloc_ent[p].op   = op_e'(bus.alloc_op[p*2 +: 2]);
      alloc_ent[p].rob  = bus.alloc_rob[p*ROB_W +: ROB_W];
      alloc_ent[p].tag1 = bus.alloc_src1_tag[p*ROB_W +: ROB_W];
      alloc_ent[p].tag2 = bus.alloc_src2_tag[p*ROB_W +: ROB_W];
      alloc_ent[p].rdy1 = bus.alloc_src1_rdy[p] | w1.hit;
      alloc_ent[p].rdy2 = bus.alloc_src2_rdy[p] | w2.hit;
      alloc_ent[p].val1 = bus.alloc_src1_rdy[p] ? bus.alloc_src1_val[p*XLEN +: XLEN] : w1.data;
      alloc_ent[p].val2 = bus.alloc_src2_rdy[p] ? bus.alloc_src2_val[p*XLEN +: XLEN] : w2.data;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_w1[i] = cdb_match(ent[i].tag1);
      ent_w2[i] = cdb_match(ent[i].tag2);
    end
  end

  // Slot assignment. Entries issuing this cycle still count as occupied; they
  // become allocatable only after the edge that frees them.
  always_comb begin
    logic [DEPTH-1:0] claimed;
    logic [OCC_W-1:0] free_cnt;
    // NOTE: every output of a combinational block gets a default before any
    // conditional update, so no path leaves a value held and no latch appears.
    claimed  = '0;
    free_cnt = '0;
    n_alloc  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_cnt = free_cnt + OCC_W'(!valid[i]);
    end
    alloc_ready_c = (free_cnt >= OCC_W'(ALLOC_W));
    for (int p = 0; p < ALLOC_W; p++) begin
      alloc_hit[p]  = 1'b0;
      alloc_slot[p] = '0;
      if (bus.alloc_valid[p] && alloc_ready_c) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!alloc_hit[p] && !valid[i] && !claimed[i]) begin
            alloc_hit[p]  = 1'b1;
            alloc_slot[p] = IDX_W'(i);
            claimed[i]    = 1'b1;
          end
        end
      end
      n_alloc = n_alloc + OCC_W'(alloc_hit[p]);
    end
  end

  // Oldest-first selection; each lane excludes entries already taken by earlier lanes.
  always_comb begin
    logic [DEPTH-1:0] eligible;
    logic [DEPTH-1:0] taken;
    logic [ROB_W-1:0] age [DEPTH];
    logic [ROB_W-1:0] best_age;
    logic [IDX_W-1:0] best_idx;
    logic             found;
    taken   = '0;
    n_issue = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age[i]      = ent[i].rob - bus.rob_head;
      eligible[i] = valid[i] && ent[i].rdy1 && ent[i].rdy2 && !bus.stall;
    end
    for (int l = 0; l < NUM_MUL; l++) begin
      found    = 1'b0;
      best_age = '0;
      best_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (eligible[i] && !is_div(ent[i].op) && !taken[i] && (!found || age[i] < best_age)) begin
          found    = 1'b1;
          best_age = age[i];
          best_idx = IDX_W'(i);
        end
      end
      if (found) taken[best_idx] = 1'b1;
      mul_sel_vld[l] = found;
      mul_sel_idx[l] = best_idx;
      n_issue        = n_issue + OCC_W'(found);
    end
    // A busy divider lane is skipped; the op stays available for the next lane.
    for (int l = 0; l < NUM_DIV; l++) begin
      found    = 1'b0;
      best_age = '0;
      best_idx = '0;
      if (bus.div_ready[l]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (eligible[i] && is_div(ent[i].op) && !taken[i] && (!found || age[i] < best_age)) begin
            found    = 1'b1;
            best_age = age[i];
            best_idx = IDX_W'(i);
          end
        end
      end
      if (found) taken[best_idx] = 1'b1;
      div_sel_vld[l] = found;
      div_sel_idx[l] = best_idx;
      n_issue        = n_issue + OCC_W'(found);
    end
    issue_mask = taken;
  end

  // Control state: flush behaves exactly like reset and discards this cycle's allocations.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      // NOTE: sequential state is always written with <= so every flop samples
      // the pre-edge values, independent of statement or process ordering.
      valid     <= '0;
      occ_q     <= '0;
      mul_v_q   <= '0;
      mul_op_q  <= '0;
      mul_rob_q <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      div_v_q   <= '0;
      div_op_q  <= '0;
      div_rob_q <= '0;
      div_a_q   <= '0;
      div_b_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_mask[i]) valid[i] <= 1'b0;
      end
      for (int p = 0; p < ALLOC_W; p++) begin
        if (alloc_hit[p]) valid[alloc_slot[p]] <= 1'b1;
      end
      occ_q <= occ_q + n_alloc - n_issue;

      for (int l = 0; l < NUM_MUL; l++) begin
        mul_v_q[l] <= mul_sel_vld[l];
        if (mul_sel_vld[l]) begin
          mul_op_q[l*2 +: 2]        <= ent[mul_sel_idx[l]].op;
          mul_rob_q[l*ROB_W +: ROB_W] <= ent[mul_sel_idx[l]].rob;
          mul_a_q[l*XLEN +: XLEN]   <= ent[mul_sel_idx[l]].val1;
          mul_b_q[l*XLEN +: XLEN]   <= ent[mul_sel_idx[l]].val2;
        end
      end
      for (int l = 0; l < NUM_DIV; l++) begin
        div_v_q[l] <= div_sel_vld[l];
        if (div_sel_vld[l]) begin
          div_op_q[l*2 +: 2]        <= ent[div_sel_idx[l]].op;
          div_rob_q[l*ROB_W +: ROB_W] <= ent[div_sel_idx[l]].rob;
          div_a_q[l*XLEN +: XLEN]   <= ent[div_sel_idx[l]].val1;
          div_b_q[l*XLEN +: XLEN]   <= ent[div_sel_idx[l]].val2;
        end
      end
    end
  end

  // NOTE: entry payload is deliberately left unreset; valid alone qualifies it,
  // and allocation rewrites every field (including the ready bits) before use.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent[i].rdy1 && ent_w1[i].hit) begin
        ent[i].rdy1 <= 1'b1;
        ent[i].val1 <= ent_w1[i].data;
      end
      if (!ent[i].rdy2 && ent_w2[i].hit) begin
        ent[i].rdy2 <= 1'b1;
        ent[i].val2 <= ent_w2[i].data;
      end
    end
    for (int p = 0; p < ALLOC_W; p++) begin
      if (alloc_hit[p]) ent[alloc_slot[p]] <= alloc_ent[p];
    end
  end

  assign bus.alloc_ready     = alloc_ready_c;
  assign bus.occupancy       = occ_q;
  assign bus.mul_issue_valid = mul_v_q;
  assign bus.mul_issue_op    = mul_op_q;
  assign bus.mul_issue_rob   = mul_rob_q;
  assign bus.mul_issue_a     = mul_a_q;
  assign bus.mul_issue_b     = mul_b_q;
  assign bus.div_issue_valid = div_v_q;
  assign bus.div_issue_op    = div_op_q;
  assign bus.div_issue_rob   = div_rob_q;
  assign bus.div_issue_a     = div_a_q;
  assign bus.div_issue_b     = div_b_q;

endmodule

// File: tb/tb_muldiv_issue_queue.sv
// Scoreboard bench for muldiv_issue_queue: expected issues are queued as ops are
// driven and compared when a lane fires; timing and occupancy are checked inline.
module tb_muldiv_issue_queue;
  localparam int DEPTH   = 8;
  localparam int ALLOC_W = 3;
  localparam int CDB_W   = 3;
  localparam int NUM_MUL = 1;
  localparam int NUM_DIV = 1;
  localparam int ROB_W   = 5;
  localparam int XLEN    = 32;

  localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, DIV = 2'b10, REM = 2'b11;

  typedef struct packed {
    logic [1:0]       op;
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
  } issue_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_issue_queue_if #(
    .DEPTH(DEPTH), .ALLOC_W(ALLOC_W), .CDB_W(CDB_W), .NUM_MUL(NUM_MUL),
    .NUM_DIV(NUM_DIV), .ROB_W(ROB_W), .XLEN(XLEN)
  ) bus ();

  muldiv_issue_queue #(
    .DEPTH(DEPTH), .ALLOC_W(ALLOC_W), .CDB_W(CDB_W), .NUM_MUL(NUM_MUL),
    .NUM_DIV(NUM_DIV), .ROB_W(ROB_W), .XLEN(XLEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int     n_vec = 0;
  int     n_err = 0;
  issue_t mul_q[$];
  issue_t div_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic issue_t exp_issue(input logic [1:0] op, input int rob,
                                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    issue_t e;
    e.op  = op;
    e.rob = ROB_W'(rob);
    e.a   = a;
    e.b   = b;
    return e;
  endfunction

  // Scoreboard side: every lane fire must match the next expected op for that lane.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mul_issue_valid[0]) begin
        check("mul_sb_nonempty", 128'(mul_q.size() != 0), 128'(1));
        if (mul_q.size() != 0)
          check("mul_issue", 128'({bus.mul_issue_op, bus.mul_issue_rob, bus.mul_issue_a, bus.mul_issue_b}),
                128'(mul_q.pop_front()));
      end
      if (bus.div_issue_valid[0]) begin
        check("div_sb_nonempty", 128'(div_q.size() != 0), 128'(1));
        if (div_q.size() != 0)
          check("div_issue", 128'({bus.div_issue_op, bus.div_issue_rob, bus.div_issue_a, bus.div_issue_b}),
                128'(div_q.pop_front()));
      end
    end
  end

  task automatic idle();
    bus.alloc_valid    = '0;
    bus.alloc_op       = '0;
    bus.alloc_rob      = '0;
    bus.alloc_src1_rdy = '0;
    bus.alloc_src2_rdy = '0;
    bus.alloc_src1_tag = '0;
    bus.alloc_src2_tag = '0;
    bus.alloc_src1_val = '0;
    bus.alloc_src2_val = '0;
    bus.cdb_valid      = '0;
    bus.cdb_tag        = '0;
    bus.cdb_data       = '0;
  endtask

  task automatic set_alloc(input int p, input logic [1:0] op, input int rob,
                           input logic r1, input int t1, input logic [XLEN-1:0] v1,
                           input logic r2, input int t2, input logic [XLEN-1:0] v2);
    bus.alloc_valid[p]                  = 1'b1;
    bus.alloc_op[p*2 +: 2]              = op;
    bus.alloc_rob[p*ROB_W +: ROB_W]     = ROB_W'(rob);
    bus.alloc_src1_rdy[p]               = r1;
    bus.alloc_src1_tag[p*ROB_W +: ROB_W] = ROB_W'(t1);
    bus.alloc_src1_val[p*XLEN +: XLEN]  = v1;
    bus.alloc_src2_rdy[p]               = r2;
    bus.alloc_src2_tag[p*ROB_W +: ROB_W] = ROB_W'(t2);
    bus.alloc_src2_val[p*XLEN +: XLEN]  = v2;
  endtask

  task automatic set_cdb(input int k, input int tag, input logic [XLEN-1:0] data);
    bus.cdb_valid[k]                 = 1'b1;
    bus.cdb_tag[k*ROB_W +: ROB_W]    = ROB_W'(tag);
    bus.cdb_data[k*XLEN +: XLEN]     = data;
  endtask

  // Allocation is only ever presented while the queue reports room.
  task automatic step();
    if (bus.alloc_valid != '0) check("alloc_ready_at_alloc", 128'(bus.alloc_ready), 128'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.stall     = 1'b0;
    bus.rob_head  = '0;
    bus.div_ready = '1;
    idle();
    step();
    step();
    rst = 1'b0;
    check("rst_occ",        128'(bus.occupancy),       128'(0));
    check("rst_alloc_rdy",  128'(bus.alloc_ready),     128'(1));
    check("rst_mul_valid",  128'(bus.mul_issue_valid), 128'(0));
    check("rst_div_valid",  128'(bus.div_issue_valid), 128'(0));

    // Basic: three ready ops, mul and div lanes fire together, then the second mul.
    bus.rob_head = 5'd4;
    set_alloc(0, MUL, 4, 1, 0, 32'd10,  1, 0, 32'd11);
    set_alloc(1, DIV, 5, 1, 0, 32'd100, 1, 0, 32'd7);
    set_alloc(2, MUL, 6, 1, 0, 32'd3,   1, 0, 32'd5);
    mul_q.push_back(exp_issue(MUL, 4, 32'd10, 32'd11));
    mul_q.push_back(exp_issue(MUL, 6, 32'd3, 32'd5));
    div_q.push_back(exp_issue(DIV, 5, 32'd100, 32'd7));
    step();
    idle();
    check("basic_occ3",     128'(bus.occupancy),       128'(3));
    check("basic_no_early", 128'(bus.mul_issue_valid), 128'(0));
    step();
    check("basic_mul0_v",   128'(bus.mul_issue_valid), 128'(1));
    check("basic_mul0_rob", 128'(bus.mul_issue_rob),   128'(4));
    check("basic_div_v",    128'(bus.div_issue_valid), 128'(1));
    check("basic_occ1",     128'(bus.occupancy),       128'(1));
    step();
    check("basic_mul1_rob", 128'(bus.mul_issue_rob),   128'(6));
    check("basic_div_off",  128'(bus.div_issue_valid), 128'(0));
    check("basic_occ0",     128'(bus.occupancy),       128'(0));
    step();
    check("basic_mul_off",  128'(bus.mul_issue_valid), 128'(0));

    // Wrap-around age: head 30 makes rob 31 older than rob 1.
    bus.rob_head = 5'd30;
    set_alloc(0, MUL,  1,  1, 0, 32'd1, 1, 0, 32'd2);
    set_alloc(1, MULH, 31, 1, 0, 32'd3, 1, 0, 32'd4);
    mul_q.push_back(exp_issue(MULH, 31, 32'd3, 32'd4));
    mul_q.push_back(exp_issue(MUL, 1, 32'd1, 32'd2));
    step();
    idle();
    step();
    check("wrap_first", 128'(bus.mul_issue_rob), 128'(31));
    step();
    check("wrap_second", 128'(bus.mul_issue_rob), 128'(1));
    step();

    // Wakeup after allocation; a higher bus with the same tag must lose.
    bus.rob_head = 5'd0;
    set_alloc(0, MUL, 2, 0, 7, 32'd0, 1, 0, 32'd5);
    mul_q.push_back(exp_issue(MUL, 2, 32'h1234, 32'd5));
    step();
    idle();
    set_cdb(0, 7, 32'h1234);
    set_cdb(1, 7, 32'hBAD0);
    step();
    idle();
    check("wake_not_yet", 128'(bus.mul_issue_valid), 128'(0));
    step();
    check("wake_issue_v", 128'(bus.mul_issue_valid), 128'(1));
    check("wake_issue_a", 128'(bus.mul_issue_a),     128'(32'h1234));
    step();

    // Same-cycle bypass: the broadcast coincides with allocation.
    set_alloc(0, MUL, 3, 0, 7, 32'd0, 1, 0, 32'd5);
    set_cdb(0, 7, 32'h1234);
    set_cdb(2, 7, 32'hBAD2);
    mul_q.push_back(exp_issue(MUL, 3, 32'h1234, 32'd5));
    step();
    idle();
    check("byp_not_yet", 128'(bus.mul_issue_valid), 128'(0));
    step();
    check("byp_issue_v", 128'(bus.mul_issue_valid), 128'(1));
    check("byp_issue_a", 128'(bus.mul_issue_a),     128'(32'h1234));
    step();

    // Divider backpressure; the REM on port 1 is older than the DIV on port 0.
    bus.rob_head  = 5'd8;
    bus.div_ready = 1'b0;
    set_alloc(0, DIV, 9, 1, 0, 32'd50, 1, 0, 32'd5);
    set_alloc(1, REM, 8, 1, 0, 32'd50, 1, 0, 32'd6);
    div_q.push_back(exp_issue(REM, 8, 32'd50, 32'd6));
    div_q.push_back(exp_issue(DIV, 9, 32'd50, 32'd5));
    step();
    idle();
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_blocked", 128'(bus.div_issue_valid), 128'(0));
    end
    bus.div_ready = 1'b1;
    step();
    check("bp_first_rob", 128'(bus.div_issue_rob), 128'(8));
    bus.div_ready = 1'b0;
    step();
    check("bp_held", 128'(bus.div_issue_valid), 128'(0));
    bus.div_ready = 1'b1;
    step();
    check("bp_second_rob", 128'(bus.div_issue_rob), 128'(9));
    step();
    check("bp_occ0", 128'(bus.occupancy), 128'(0));

    // Fill to 6 with unready ops; alloc_ready drops, and returns after one issues.
    bus.rob_head = 5'd0;
    for (int p = 0; p < 3; p++) set_alloc(p, MUL, 10 + p, 0, 20 + p, 32'd0, 1, 0, 32'd1);
    step();
    idle();
    check("full_occ3",  128'(bus.occupancy),   128'(3));
    check("full_rdy3",  128'(bus.alloc_ready), 128'(1));
    for (int p = 0; p < 3; p++) set_alloc(p, MUL, 13 + p, 0, 23 + p, 32'd0, 1, 0, 32'd1);
    step();
    idle();
    check("full_occ6",  128'(bus.occupancy),   128'(6));
    check("full_rdy6",  128'(bus.alloc_ready), 128'(0));
    set_cdb(0, 21, 32'h77);
    mul_q.push_back(exp_issue(MUL, 11, 32'h77, 32'd1));
    step();
    idle();
    check("full_rdy_woken", 128'(bus.alloc_ready), 128'(0));
    step();
    check("full_issue_rob", 128'(bus.mul_issue_rob), 128'(11));
    check("full_occ5",      128'(bus.occupancy),     128'(5));
    check("full_rdy_after", 128'(bus.alloc_ready),   128'(1));

    // Flush with five entries, one selected this cycle, a wakeup and an allocation.
    set_cdb(0, 20, 32'h99);
    step();
    idle();
    bus.flush = 1'b1;
    set_cdb(0, 22, 32'h88);
    set_alloc(0, MUL, 16, 1, 0, 32'd1, 1, 0, 32'd1);
    step();
    bus.flush = 1'b0;
    idle();
    check("flush_occ",       128'(bus.occupancy),       128'(0));
    check("flush_mul_valid", 128'(bus.mul_issue_valid), 128'(0));
    check("flush_div_valid", 128'(bus.div_issue_valid), 128'(0));
    check("flush_alloc_rdy", 128'(bus.alloc_ready),     128'(1));

    // Reused slot must wait for its own producer, not inherit stale ready state.
    set_alloc(0, MUL, 12, 0, 22, 32'd0, 1, 0, 32'd2);
    mul_q.push_back(exp_issue(MUL, 12, 32'h55, 32'd2));
    step();
    idle();
    step();
    check("reuse_waits", 128'(bus.mul_issue_valid), 128'(0));
    check("reuse_occ1",  128'(bus.occupancy),       128'(1));
    set_cdb(0, 22, 32'h55);
    step();
    idle();
    step();
    check("reuse_issue_a", 128'(bus.mul_issue_a), 128'(32'h55));
    check("reuse_occ0",    128'(bus.occupancy),   128'(0));

    // Stall blocks issue but not allocation.
    bus.stall = 1'b1;
    set_alloc(0, MUL, 1, 1, 0, 32'd6, 1, 0, 32'd7);
    mul_q.push_back(exp_issue(MUL, 1, 32'd6, 32'd7));
    step();
    idle();
    for (int c = 0; c < 2; c++) begin
      step();
      check("stall_blocked", 128'(bus.mul_issue_valid), 128'(0));
    end
    check("stall_occ1", 128'(bus.occupancy), 128'(1));
    bus.stall = 1'b0;
    step();
    check("stall_release", 128'(bus.mul_issue_valid), 128'(1));
    step();

    for (int c = 0; c < 20 && (mul_q.size() != 0 || div_q.size() != 0); c++) step();
    check("sb_drained", 128'(mul_q.size() + div_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_queue.md
Name: muldiv_issue_queue

Overview:
- Parametrised successor to the fixed two-slot mul/div dispatch.
- Owns a DEPTH-entry mul/div reservation queue and accepts up to ALLOC_W renamed ops per cycle.
- Captures operands from CDB_W result buses.
- Each cycle, issues the oldest ready ops to NUM_MUL pipelined-multiplier lanes and to NUM_DIV iterative-divider lanes; divider lanes have ready/valid backpressure. Ages are wrap-aware, relative to the ROB head.

Parameters:
DEPTH, 8, queue entries (>= ALLOC_W)
ALLOC_W, 3, allocation ports per cycle
CDB_W, 3, result broadcast buses
NUM_MUL, 1, multiply issue lanes
NUM_DIV, 1, divide issue lanes
ROB_W, 5, ROB index width
XLEN, 32, operand width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  pipeline flush
stall  in  1  completion-buffer stall; blocks issue
rob_head  in  ROB_W  oldest in-flight ROB index
alloc_valid  in  ALLOC_W  per-port allocate request
alloc_op  in  ALLOC_W*2  00 mul, 01 mulh, 10 div, 11 rem
alloc_rob  in  ALLOC_W*ROB_W  destination ROB index
alloc_src1_rdy / alloc_src2_rdy  in  ALLOC_W  operand already valid
alloc_src1_tag / alloc_src2_tag  in  ALLOC_W*ROB_W  producer tag if not ready
alloc_src1_val / alloc_src2_val  in  ALLOC_W*XLEN  operand value if ready
alloc_ready  out  1  at least ALLOC_W free entries
cdb_valid  in  CDB_W  broadcast valid
cdb_tag  in  CDB_W*ROB_W  broadcast ROB tag
cdb_data  in  CDB_W*XLEN  broadcast value
mul_issue_valid  out  NUM_MUL  registered issue pulse
mul_issue_op  out  NUM_MUL*2  op
mul_issue_rob  out  NUM_MUL*ROB_W  ROB index
mul_issue_a / mul_issue_b  out  NUM_MUL*XLEN  operands
div_ready  in  NUM_DIV  divider lane idle and able to accept
div_issue_valid / div_issue_op / div_issue_rob / div_issue_a / div_issue_b  out  per-lane (NUM_DIV scaled)  same as mul lanes
occupancy  out  $clog2(DEPTH+1)  valid entry count

Behaviour:
- Reset/flush (both synchronous, flush equal to rst): all entries invalid; all issue outputs 0; occupancy 0. alloc_ready is 1 after reset. Allocation and CDB capture in a flush cycle are discarded.
- Entry state: valid, op, rob, rdy1/rdy2, tag1/tag2, val1/val2.
- Allocation:
  - Written at the clock edge when alloc_valid[p] && alloc_ready.
  - Ports fill the lowest-index free entries, port 0 first.
  - alloc_valid while !alloc_ready is dropped; the bench asserts this never happens.
- alloc_ready is combinational: free_count >= ALLOC_W. free_count excludes entries issuing this cycle; they are freed at the edge.
- Wakeup:
  - At each edge, every valid entry with rdyN=0 and tagN == cdb_tag[k] with cdb_valid[k] sets rdyN=1, valN=cdb_data[k].
  - Same-cycle bypass on allocation: an allocating op whose not-ready tag matches a current CDB broadcast is written as ready with that data.
  - Multiple CDB matches: the lowest k wins.
- Eligible: valid && rdy1 && rdy2 && !stall.
- Age key: (rob - rob_head) mod 2^ROB_W; a smaller key is older. Keys are unique, so there are no ties.
- Selection (combinational, sequential per lane):
  - mul lane 0 takes the oldest eligible mul/mulh, lane 1 the next oldest, and so on.
  - div lane l takes the oldest remaining eligible div/rem only if div_ready[l]. A lane with div_ready=0 is skipped and the op goes to the next ready lane.
  - Each entry is selected at most once per cycle.
- Issue registers: a selected op is latched into the lane's issue register at the edge and its entry is freed at the same edge. issue_valid is high for exactly one cycle per op; the lane returns to valid=0 when nothing is selected.
- Latency: op allocated with both operands ready at edge T → eligible in cycle T..T+1 → issue_valid high in cycle after edge T+1 (minimum 2 edges). An operand woken by CDB at edge T issues at edge T+1.
- stall: no selection and no issue; issue registers clear to valid=0. Allocation and wakeup continue.
- Simultaneous allocate and issue in one cycle is legal. Freed slots become visible to allocation in the next cycle.
- occupancy is a registered count, updated at each edge by +allocs −issues.

Test Plan:
- Reset, then 3 allocs (mul rob 4, div rob 5, mul rob 6, all ready), rob_head=4 → next-next cycle: mul lane issues rob4, div lane issues rob5; one cycle later mul issues rob6; occupancy 3→1→0.
- Wrap-around: rob_head=30, ready muls rob 1 and rob 31 → rob31 issues before rob1.
- Wakeup: mul rob 2 with src1 tag 7 not ready; cdb_valid with tag 7, data 0x1234 at edge T → issues at edge T+1 with mul_issue_a=0x1234. Repeat with CDB in the same cycle as allocation → identical result.
- Backpressure: div_ready=0 for 5 cycles with 2 ready divs queued → no div_issue_valid. div_ready=1 → older div issues; the next issues one cycle later only if div_ready stays 1.
- Full: DEPTH=8, allocate 6 ops with operands never ready → alloc_ready=0 with 6 occupied (ALLOC_W=3); wake one → after issue, alloc_ready=1.
- Flush mid-operation: 5 entries and an issue in flight; assert flush → next cycle occupancy 0, all issue_valid 0, and CDB wakeups in the flush cycle are ignored.
